// File: rtl/router_input_port.sv
// ---------------------------------------------------------------------------
// router_input_port
// Mesh-router input port with two single-entry virtual-channel buffers.
// Each cycle one VC faces the link (external, index = polarity) and the other
// faces the switch (internal). The internal VC is XY-routed: a one-hot output
// request is raised and the packet is presented with its hop count reduced.
//
// Ports
//   clk       in   1             clock, rising edge
//   reset     in   1             synchronous, active-high
//   polarity  out  1             current polarity (external VC index)
//   in_si     in   1             upstream send strobe
//   in_ri     out  1             external VC buffer empty (combinational)
//   in_di     in   PACKET_WIDTH  upstream packet
//   req       out  5             one-hot request {PE,W,E,S,N} (combinational)
//   gnt       in   1             switch grant for the current request
//   dout      out  PACKET_WIDTH  hop-adjusted packet, valid when req != 0
//   err       out  1             sticky wrong-VC arrival flag
//
// Packet layout: [63] vc, [62] dx (1 = west), [61] dy (1 = south),
// [55:48] hx, [47:40] hy, [31:0] payload. PACKET_WIDTH must be >= 64.
// ---------------------------------------------------------------------------
module router_input_port #(
    parameter int unsigned PACKET_WIDTH = 64,
    parameter int unsigned HOP_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    polarity,
    input  logic                    in_si,
    output logic                    in_ri,
    input  logic [PACKET_WIDTH-1:0] in_di,
    output logic [4:0]              req,
    input  logic                    gnt,
    output logic [PACKET_WIDTH-1:0] dout,
    output logic                    err
);

    localparam int unsigned VC_BIT = 63;
    localparam int unsigned DX_BIT = 62;
    localparam int unsigned DY_BIT = 61;
    localparam int unsigned HX_LSB = 48;
    localparam int unsigned HY_LSB = 40;

    localparam logic [4:0] REQ_N  = 5'b00001;
    localparam logic [4:0] REQ_S  = 5'b00010;
    localparam logic [4:0] REQ_E  = 5'b00100;
    localparam logic [4:0] REQ_W  = 5'b01000;
    localparam logic [4:0] REQ_PE = 5'b10000;

    logic                    r_polarity;
    logic [1:0]              r_full;
    logic [PACKET_WIDTH-1:0] r_buf [2];
    logic                    r_err;

    logic                    w_ext;
    logic                    w_int;
    logic [PACKET_WIDTH-1:0] w_int_pkt;
    logic [HOP_W-1:0]        w_hx;
    logic [HOP_W-1:0]        w_hy;
    logic                    w_accept;
    logic                    w_vc_err;
    logic                    w_deq;

    // VC roles swap every cycle
    assign w_ext     = r_polarity;
    assign w_int     = ~r_polarity;
    assign w_int_pkt = r_buf[w_int];
    assign w_hx      = w_int_pkt[HX_LSB +: HOP_W];
    assign w_hy      = w_int_pkt[HY_LSB +: HOP_W];

    assign polarity = r_polarity;
    assign err      = r_err;
    assign in_ri    = ~r_full[w_ext];

    // A packet tagged for the wrong VC is dropped regardless of readiness
    assign w_vc_err = in_si & (in_di[VC_BIT] != w_ext);
    assign w_accept = in_si & in_ri & (in_di[VC_BIT] == w_ext);
    assign w_deq    = gnt & (req != 5'b00000);

    // XY route of the internal VC: X first, then Y, then eject
    always_comb begin
        req  = '0;
        dout = '0;
        if (r_full[w_int]) begin
            dout = w_int_pkt;
            if (w_hx != '0) begin
                req                   = w_int_pkt[DX_BIT] ? REQ_W : REQ_E;
                dout[HX_LSB +: HOP_W] = w_hx - HOP_W'(1);
            end else if (w_hy != '0) begin
                req                   = w_int_pkt[DY_BIT] ? REQ_S : REQ_N;
                dout[HY_LSB +: HOP_W] = w_hy - HOP_W'(1);
            end else begin
                req = REQ_PE;
            end
        end
    end

    // Accept and dequeue always target different buffers, so both may fire
    always_ff @(posedge clk) begin
        if (reset) begin
            r_polarity <= 1'b0;
            r_full     <= 2'b00;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_polarity <= ~r_polarity;
            if (w_accept) begin
                r_buf[w_ext]  <= in_di;
                r_full[w_ext] <= 1'b1;
            end
            if (w_deq) begin
                r_full[w_int] <= 1'b0;
            end
            if (w_vc_err) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_input_port.sv
module tb_router_input_port;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        in_si;
    logic        in_ri;
    logic [63:0] in_di;
    logic [4:0]  req;
    logic        gnt;
    logic [63:0] dout;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: two optional packets plus polarity and error flag
    logic        m_pol;
    logic        m_full [2];
    logic [63:0] m_buf  [2];
    logic        m_err;

    router_input_port #(.PACKET_WIDTH(64), .HOP_W(8)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .in_si(in_si), .in_ri(in_ri), .in_di(in_di),
        .req(req), .gnt(gnt), .dout(dout), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic vc, input logic dx, input logic dy,
                                       input logic [7:0] hx, input logic [7:0] hy,
                                       input logic [31:0] pl);
        logic [63:0] p;
        p = {$urandom, $urandom};
        p[63] = vc; p[62] = dx; p[61] = dy;
        p[55:48] = hx; p[47:40] = hy; p[31:0] = pl;
        return p;
    endfunction

    // XY routing rule: travel X until exhausted, then Y, then eject
    function automatic void model_route(input logic full, input logic [63:0] pkt,
                                        output logic [4:0] rq, output logic [63:0] d);
        int hx, hy;
        hx = int'(pkt[55:48]);
        hy = int'(pkt[47:40]);
        rq = 5'b00000;
        d  = 64'h0;
        if (!full) return;
        d = pkt;
        if (hx > 0) begin
            d[55:48] = 8'(hx - 1);
            rq = pkt[62] ? 5'b01000 : 5'b00100;
        end else if (hy > 0) begin
            d[47:40] = 8'(hy - 1);
            rq = pkt[61] ? 5'b00010 : 5'b00001;
        end else begin
            rq = 5'b10000;
        end
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge
    task automatic tick(input logic si, input logic [63:0] di, input logic g, input logic rst);
        logic [4:0]  rq;
        logic [63:0] d;
        logic        e, i;
        in_si = si; in_di = di; gnt = g; reset = rst;
        @(posedge clk);
        e = m_pol;
        i = !m_pol;
        model_route(m_full[i], m_buf[i], rq, d);
        if (rst) begin
            m_pol = 1'b0; m_err = 1'b0;
            m_full[0] = 1'b0; m_full[1] = 1'b0;
            m_buf[0] = 64'h0; m_buf[1] = 64'h0;
        end else begin
            if (si && di[63] != e) m_err = 1'b1;
            else if (si && !m_full[e]) begin
                m_buf[e] = di;
                m_full[e] = 1'b1;
            end
            if (g && rq != 5'b00000) m_full[i] = 1'b0;
            m_pol = !m_pol;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic align_pol(input logic v);
        if (m_pol != v) idle(1);
    endtask

    task automatic test_reset;
        logic exp_pol;
        tick(1'b0, 64'h0, 1'b0, 1'b1);
        tick(1'b1, mk(1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 32'h1), 1'b1, 1'b1);
        n_checks++;
        if ({polarity, in_ri, req, dout, err} !== {1'b0, 1'b1, 5'b0, 64'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: got pol=%b ri=%b req=%b dout=%h err=%b, expected 0 1 00000 0 0",
                     polarity, in_ri, req, dout, err);
        end
        exp_pol = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            exp_pol = !exp_pol;
            n_checks++;
            if (polarity !== exp_pol) begin
                n_errors++;
                $display("FAIL pol_toggle[%0d]: got %b expected %b", k, polarity, exp_pol);
            end
        end
    endtask

    task automatic test_east_hop;
        align_pol(1'b0);
        tick(1'b1, mk(1'b0, 1'b0, 1'b0, 8'd2, 8'd0, 32'h1234), 1'b0, 1'b0);
        n_checks++;
        if (req !== 5'b00100 || dout[55:48] !== 8'd1) begin
            n_errors++;
            $display("FAIL east_req: got req=%b hx=%0d expected 00100 hx=1", req, dout[55:48]);
        end
        tick(1'b0, 64'h0, 1'b1, 1'b0);
        n_checks++;
        if (req !== 5'b00000 || in_ri !== 1'b1 || polarity !== 1'b0) begin
            n_errors++;
            $display("FAIL east_drain: got req=%b ri=%b pol=%b expected 00000 1 0", req, in_ri, polarity);
        end
    endtask

    task automatic test_eject;
        logic [63:0] p;
        align_pol(1'b1);
        p = mk(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 32'hDEADBEEF);
        tick(1'b1, p, 1'b0, 1'b0);
        n_checks++;
        if (req !== 5'b10000 || dout !== p) begin
            n_errors++;
            $display("FAIL eject: got req=%b dout=%h expected 10000 %h", req, dout, p);
        end
        tick(1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure;
        align_pol(1'b0);
        tick(1'b1, mk(1'b0, 1'b0, 1'b1, 8'd0, 8'd3, 32'h55), 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (m_pol) begin
                if (req !== 5'b00010 || dout[47:40] !== 8'd2) begin
                    n_errors++;
                    $display("FAIL south_blocked[%0d]: got req=%b hy=%0d expected 00010 hy=2", k, req, dout[47:40]);
                end
            end else if (req !== 5'b00000 || in_ri !== 1'b0) begin
                n_errors++;
                $display("FAIL south_idle[%0d]: got req=%b ri=%b expected 00000 0", k, req, in_ri);
            end
            idle(1);
        end
        align_pol(1'b1);
        tick(1'b0, 64'h0, 1'b1, 1'b0);
        n_checks++;
        if (in_ri !== 1'b1) begin
            n_errors++;
            $display("FAIL south_release: got ri=%b expected 1", in_ri);
        end
    endtask

    task automatic test_wrong_vc;
        align_pol(1'b0);
        tick(1'b1, mk(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 32'h9), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (err !== 1'b1 || req !== 5'b00000) begin
                n_errors++;
                $display("FAIL wrong_vc[%0d]: got err=%b req=%b expected 1 00000", k, err, req);
            end
            idle(1);
        end
        tick(1'b0, 64'h0, 1'b0, 1'b1);
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clear: got err=%b expected 0", err);
        end
    endtask

    task automatic test_reset_mid;
        align_pol(1'b0);
        tick(1'b1, mk(1'b0, 1'b1, 1'b0, 8'd4, 8'd0, 32'h1), 1'b0, 1'b0);
        tick(1'b1, mk(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 32'h2), 1'b0, 1'b0);
        n_checks++;
        if (req !== 5'b10000 || in_ri !== 1'b0) begin
            n_errors++;
            $display("FAIL both_full: got req=%b ri=%b expected 10000 0", req, in_ri);
        end
        tick(1'b0, 64'h0, 1'b1, 1'b1);
        n_checks++;
        if ({polarity, in_ri, req} !== {1'b0, 1'b1, 5'b00000}) begin
            n_errors++;
            $display("FAIL reset_mid: got pol=%b ri=%b req=%b expected 0 1 00000", polarity, in_ri, req);
        end
        idle(1);
        n_checks++;
        if (req !== 5'b00000 || in_ri !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_after: got req=%b ri=%b expected 00000 1", req, in_ri);
        end
    endtask

    task automatic test_random;
        logic [4:0]  e_rq;
        logic [63:0] e_d;
        logic        vc, si, g, rst;
        for (int k = 0; k < 400; k++) begin
            model_route(m_full[!m_pol], m_buf[!m_pol], e_rq, e_d);
            n_checks++;
            if (polarity !== m_pol || in_ri !== !m_full[m_pol] || req !== e_rq ||
                dout !== e_d || err !== m_err) begin
                n_errors++;
                $display("FAIL random[%0d]: got pol=%b ri=%b req=%b dout=%h err=%b expected %b %b %b %h %b",
                         k, polarity, in_ri, req, dout, err,
                         m_pol, !m_full[m_pol], e_rq, e_d, m_err);
            end
            si  = ($urandom_range(0, 99) < 60);
            vc  = ($urandom_range(0, 99) < 4) ? !m_pol : m_pol;
            g   = ($urandom_range(0, 99) < 55);
            rst = ($urandom_range(0, 99) < 3);
            tick(si, mk(vc, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 2)),
                        8'($urandom_range(0, 2)), $urandom), g, rst);
        end
    endtask

    initial begin
        m_pol = 1'b0; m_err = 1'b0;
        m_full[0] = 1'b0; m_full[1] = 1'b0;
        m_buf[0] = 64'h0; m_buf[1] = 64'h0;
        reset = 1'b1; in_si = 1'b0; in_di = 64'h0; gnt = 1'b0;
        @(negedge clk);
        test_reset;
        test_east_hop;
        test_eject;
        test_backpressure;
        test_wrong_vc;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
